// File: rtl/pll_drp_sequencer_if.sv
// Bundle of control, status, DRP and PLL-side signals of pll_drp_sequencer.
// master: the sequencer. slave: the requester plus the PLL side.
interface pll_drp_sequencer_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;

    logic              start;
    logic              cfg_sel;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] drp_addr;
    logic [DATA_W-1:0] drp_di;
    logic [DATA_W-1:0] drp_do;
    logic              drp_en;
    logic              drp_we;
    logic              drp_rdy;
    logic              pll_rst;
    logic              pll_locked;
    logic              locked_out;

    modport master (
        input  start, cfg_sel, drp_do, drp_rdy, pll_locked,
        output busy, done, err, drp_addr, drp_di, drp_en, drp_we, pll_rst, locked_out
    );

    modport slave (
        output start, cfg_sel, drp_do, drp_rdy, pll_locked,
        input  busy, done, err, drp_addr, drp_di, drp_en, drp_we, pll_rst, locked_out
    );
endinterface

// File: rtl/pll_drp_sequencer.sv
// PLLE2_ADV run-time reprogramming: hold PLL in reset, read-modify-write each
// entry of the selected table over DRP, release reset and wait for relock.
// Optional macro PLL_DRP_LOCK_TIMEOUT_EN bounds the relock wait by LOCK_TIMEOUT.
module pll_drp_sequencer #(
    parameter int unsigned                NUM_REGS     = 4,
    parameter logic [NUM_REGS*39-1:0]     CFG0_TABLE   = '0,
    parameter logic [NUM_REGS*39-1:0]     CFG1_TABLE   = '0,
    parameter int unsigned                DRDY_TIMEOUT = 1023,
    parameter int unsigned                LOCK_TIMEOUT = 65535
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    pll_drp_sequencer_if.master   bus
);
    localparam int unsigned ENTRY_W = 39;
    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    typedef enum logic [3:0] {
        IDLE, RST, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK, DONE, ERR
    } state_t;

    state_t                  state_q, state_d;
    logic                    sel_q, sel_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [6:0]              drp_addr_q, drp_addr_d;
    logic [15:0]             drp_di_q, drp_di_d;
    logic                    drp_en_q, drp_en_d;
    logic                    drp_we_q, drp_we_d;
    logic                    pll_rst_q, pll_rst_d;
    logic [NUM_REGS*39-1:0]  tbl_c;
    drp_entry_t              entry_c;

    // Table entry addressed by the next-cycle selection and index.
    always_comb begin
        tbl_c   = sel_d ? CFG1_TABLE : CFG0_TABLE;
        entry_c = drp_entry_t'(tbl_c[32'(idx_d) * ENTRY_W +: ENTRY_W]);
    end

    // Next-state logic; outputs are registered from the state being entered.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        drp_addr_d = drp_addr_q;
        drp_di_d   = drp_di_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sel_d   = bus.cfg_sel;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RST;
                end
            end
            RST: state_d = RD;
            RD: begin
                cnt_d   = '0;
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (bus.drp_rdy) begin
                    drp_di_d = (bus.drp_do & entry_c.mask) | (entry_c.data & ~entry_c.mask);
                    state_d  = WR;
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            WR: begin
                cnt_d   = '0;
                state_d = WAIT_WR;
            end
            WAIT_WR: begin
                if (bus.drp_rdy) begin
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        state_d = RELEASE;
                    end else begin
                        idx_d   = IDX_W'(idx_q + 1'b1);
                        state_d = RD;
                    end
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            RELEASE: begin
                cnt_d   = '0;
                state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (bus.pll_locked) begin
                    state_d = DONE;
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
`endif
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == ERR) err_d = 1'b1;
        if (state_d == RD)  drp_addr_d = entry_c.addr;

        busy_d    = !(state_d inside {IDLE, DONE, ERR});
        done_d    = (state_d == DONE);
        drp_en_d  = (state_d inside {RD, WR});
        drp_we_d  = (state_d == WR);
        pll_rst_d = (state_d inside {RST, RD, WAIT_RD, WR, WAIT_WR});
    end

    // State and registered outputs; reset aborts any sequence at once.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            drp_addr_q <= '0;
            drp_di_q   <= '0;
            drp_en_q   <= 1'b0;
            drp_we_q   <= 1'b0;
            pll_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            drp_addr_q <= drp_addr_d;
            drp_di_q   <= drp_di_d;
            drp_en_q   <= drp_en_d;
            drp_we_q   <= drp_we_d;
            pll_rst_q  <= pll_rst_d;
        end
    end

    // Port drive; locked_out masks the PLL lock while a sequence runs.
    always_comb begin
        bus.busy       = busy_q;
        bus.done       = done_q;
        bus.err        = err_q;
        bus.drp_addr   = drp_addr_q;
        bus.drp_di     = drp_di_q;
        bus.drp_en     = drp_en_q;
        bus.drp_we     = drp_we_q;
        bus.pll_rst    = pll_rst_q;
        bus.locked_out = bus.pll_locked & ~busy_q;
    end
endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Directed bench for pll_drp_sequencer with a DRP register model and a
// PLL lock model that relocks LOCK_DLY+1 edges after pll_rst drops.
module tb_pll_drp_sequencer;
    localparam int unsigned N        = 4;
    localparam int unsigned DRDY_TO  = 15;
    localparam int unsigned LOCK_TO  = 100;
    localparam int          LOCK_DLY = 2;

    localparam logic [N*39-1:0] CFG0 = {
        7'h0B, 16'h0000, 16'h1234,
        7'h0A, 16'hFFFF, 16'h0000,
        7'h09, 16'h00FF, 16'hAB00,
        7'h08, 16'h1000, 16'h0186
    };
    localparam logic [N*39-1:0] CFG1 = {
        7'h4E, 16'hFF00, 16'h00AA,
        7'h16, 16'h0000, 16'hFFFF,
        7'h15, 16'hF000, 16'h0ABC,
        7'h14, 16'h0F0F, 16'h5050
    };

    logic clk_sys = 1'b0;
    logic rst_sys;
    pll_drp_sequencer_if bus ();

    pll_drp_sequencer #(
        .NUM_REGS(N), .CFG0_TABLE(CFG0), .CFG1_TABLE(CFG1),
        .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)
    ) u_dut (
        .clk_sys(clk_sys),
        .rst_sys(rst_sys),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int   total = 0;
    int   bad   = 0;
    bit   rdy_en = 1'b1;
    bit   lock_hold = 1'b0;
    int   done_cnt = 0;
    int   adj_viol = 0;
    bit   prev_en = 1'b0;
    logic [7:0]  ops[$];
    logic [15:0] wdat[$];
    logic [15:0] mem [128];
    bit          written [128];
    int          lcnt = 0;

    function automatic logic [15:0] init_val(input logic [6:0] a);
        case (a)
            7'h08: return 16'hF3FF;
            7'h09: return 16'h1234;
            7'h0A: return 16'hCAFE;
            7'h0B: return 16'hFFFF;
            7'h14: return 16'hAAAA;
            7'h15: return 16'h1111;
            7'h16: return 16'h2222;
            7'h4E: return 16'h0F0F;
            default: return 16'h0000;
        endcase
    endfunction

    // DRP slave: DRDY one cycle after DEN, reads return stored or preset values.
    always @(posedge clk_sys) begin
        bus.drp_rdy <= 1'b0;
        if (bus.drp_en && rdy_en) begin
            bus.drp_rdy <= 1'b1;
            if (bus.drp_we) begin
                mem[bus.drp_addr]     <= bus.drp_di;
                written[bus.drp_addr] <= 1'b1;
            end else begin
                bus.drp_do <= written[bus.drp_addr] ? mem[bus.drp_addr] : init_val(bus.drp_addr);
            end
        end
    end

    // PLL lock: lost while in reset or held, regained after a fixed delay.
    always @(posedge clk_sys) begin
        if (bus.pll_rst || lock_hold) begin
            lcnt           <= 0;
            bus.pll_locked <= 1'b0;
        end else if (lcnt >= LOCK_DLY) begin
            bus.pll_locked <= 1'b1;
        end else begin
            lcnt <= lcnt + 1;
        end
    end

    // Transaction log, done count and back-to-back DEN detector.
    always @(posedge clk_sys) begin
        if (bus.drp_en) begin
            ops.push_back({bus.drp_we, bus.drp_addr});
            if (bus.drp_we) wdat.push_back(bus.drp_di);
        end
        if (bus.drp_en && prev_en) adj_viol++;
        prev_en = bus.drp_en;
        if (bus.done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start and follow the sequence until done (or budget expiry).
    task automatic run_seq(input bit sel, input int extra_at, input bit hit_done,
                           output int done_at, output int busy_n, output int prst_n,
                           output int lo_busy_n, output logic err1);
        done_at = -1; busy_n = 0; prst_n = 0; lo_busy_n = 0; err1 = 1'bx;
        @(negedge clk_sys);
        bus.start = 1'b1; bus.cfg_sel = sel;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk_sys);
            bus.start = 1'b0; bus.cfg_sel = ~sel;
            if (n == 1) err1 = bus.err;
            if (bus.busy) busy_n++;
            if (bus.pll_rst) prst_n++;
            if (bus.busy && bus.locked_out) lo_busy_n++;
            if (n == extra_at) bus.start = 1'b1;
            if (bus.done) begin
                done_at = n;
                if (hit_done) bus.start = 1'b1;
                break;
            end
        end
        @(negedge clk_sys);
        bus.start = 1'b0;
    endtask

    initial begin
        int          d_at, b_n, p_n, lo_n, base, wbase, e_at, dn, cfg0_hits;
        logic        e1;
        logic [7:0]  exp_ops0 [8];
        logic [7:0]  exp_ops1 [8];
        logic [15:0] exp_w0 [4];
        logic [15:0] exp_w1 [4];
        exp_ops0 = '{8'h08, 8'h88, 8'h09, 8'h89, 8'h0A, 8'h8A, 8'h0B, 8'h8B};
        exp_ops1 = '{8'h14, 8'h94, 8'h15, 8'h95, 8'h16, 8'h96, 8'h4E, 8'hCE};
        exp_w0   = '{16'h1186, 16'hAB34, 16'hCAFE, 16'h1234};
        exp_w1   = '{16'h5A5A, 16'h1ABC, 16'hFFFF, 16'h0FAA};
        for (int i = 0; i < 128; i++) written[i] = 1'b0;

        rst_sys = 1'b1; bus.start = 1'b0; bus.cfg_sel = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("reset_ctl", {bus.busy, bus.done, bus.err, bus.drp_en, bus.drp_we, bus.pll_rst}, 6'b0);
        chk("reset_addr", bus.drp_addr, 7'h00);
        chk("reset_di", bus.drp_di, 16'h0000);
        rst_sys = 1'b0;
        repeat (6) @(negedge clk_sys);
        chk("idle_locked_out", bus.locked_out, 1'b1);
        lock_hold = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("locked_out_follows_low", bus.locked_out, 1'b0);
        lock_hold = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("locked_out_follows_high", bus.locked_out, 1'b1);

        // CFG0 with a start while busy and a start coincident with done.
        base = ops.size(); wbase = wdat.size();
        run_seq(1'b0, 5, 1'b1, d_at, b_n, p_n, lo_n, e1);
        chk("cfg0_done_latency", d_at, 22);
        chk("cfg0_busy_cycles", b_n, 21);
        chk("cfg0_pll_rst_cycles", p_n, 17);
        chk("cfg0_locked_out_masked", lo_n, 0);
        chk("cfg0_op_count", ops.size() - base, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("cfg0_op%0d", i), ops[base+i], exp_ops0[i]);
        for (int i = 0; i < 4; i++) chk($sformatf("cfg0_wdata%0d", i), wdat[wbase+i], exp_w0[i]);
        repeat (5) @(negedge clk_sys);
        chk("cfg0_single_done", done_cnt, 1);
        chk("cfg0_idle_after", bus.busy, 1'b0);
        chk("cfg0_err_clear", bus.err, 1'b0);
        chk("cfg0_locked_out_after", bus.locked_out, 1'b1);

        // CFG1 selected.
        base = ops.size(); wbase = wdat.size();
        run_seq(1'b1, 0, 1'b0, d_at, b_n, p_n, lo_n, e1);
        chk("cfg1_done_latency", d_at, 22);
        chk("cfg1_op_count", ops.size() - base, 8);
        cfg0_hits = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cfg1_op%0d", i), ops[base+i], exp_ops1[i]);
            if (ops[base+i][6:0] inside {7'h08, 7'h09, 7'h0A, 7'h0B}) cfg0_hits++;
        end
        chk("cfg1_no_cfg0_addr", cfg0_hits, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("cfg1_wdata%0d", i), wdat[wbase+i], exp_w1[i]);
        repeat (3) @(negedge clk_sys);
        chk("cfg1_done_count", done_cnt, 2);

        // DRDY never arrives.
        rdy_en = 1'b0; e_at = -1;
        @(negedge clk_sys);
        bus.start = 1'b1; bus.cfg_sel = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk_sys);
            bus.start = 1'b0;
            if (bus.err) begin e_at = n; break; end
        end
        chk("drdy_timeout_at", e_at, 18);
        chk("drdy_timeout_busy", bus.busy, 1'b0);
        chk("drdy_timeout_pll_rst", bus.pll_rst, 1'b0);
        chk("drdy_timeout_no_done", bus.done, 1'b0);
        repeat (3) @(negedge clk_sys);
        chk("err_sticky", bus.err, 1'b1);
        rdy_en = 1'b1;
        repeat (5) @(negedge clk_sys);
        run_seq(1'b0, 0, 1'b0, d_at, b_n, p_n, lo_n, e1);
        chk("err_cleared_by_start", e1, 1'b0);
        chk("rerun_done_latency", d_at, 22);
        chk("done_count_3", done_cnt, 3);

        // PLL never relocks while held.
        lock_hold = 1'b1; e_at = -1; dn = done_cnt;
        @(negedge clk_sys);
        bus.start = 1'b1; bus.cfg_sel = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk_sys);
            bus.start = 1'b0;
            if (bus.err && e_at < 0) e_at = n;
        end
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
        chk("lock_timeout_at", e_at, 119);
        chk("lock_timeout_busy", bus.busy, 1'b0);
        chk("lock_timeout_no_done", done_cnt - dn, 0);
        lock_hold = 1'b0;
        repeat (5) @(negedge clk_sys);
`else
        chk("lock_wait_no_err", e_at, -1);
        chk("lock_wait_busy", bus.busy, 1'b1);
        chk("lock_wait_no_done", done_cnt - dn, 0);
        lock_hold = 1'b0; d_at = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_sys);
            if (bus.done) begin d_at = n; break; end
        end
        chk("lock_release_done_at", d_at, 4);
        @(negedge clk_sys);
        chk("lock_release_idle", bus.busy, 1'b0);
        chk("lock_release_done_count", done_cnt - dn, 1);
`endif
        chk("no_back_to_back_den", adj_viol, 0);

        // Reset asserted mid-sequence while DEN and pll_rst are high.
        @(negedge clk_sys);
        bus.start = 1'b1; bus.cfg_sel = 1'b0;
        @(negedge clk_sys);
        bus.start = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("midseq_pre_rst", {bus.pll_rst, bus.drp_en, bus.busy}, 3'b111);
        rst_sys = 1'b1;
        #1;
        chk("midseq_async_clear", {bus.busy, bus.done, bus.err, bus.drp_en, bus.drp_we, bus.pll_rst}, 6'b0);
        @(negedge clk_sys);
        rst_sys = 1'b0;
        repeat (6) @(negedge clk_sys);
        chk("post_reset_idle", {bus.busy, bus.locked_out}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
